// File: rtl/thumb_seq.sv
// Multi-cycle Thumb instruction sequencer: fetch, classify by ir[15:13], then walk
// EXEC/MEM/WB/BRANCH while emitting one-cycle datapath strobes.
module thumb_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        halt,
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    output logic [15:0] ir,
    output logic [2:0]  op_class,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    input  logic        cond_pass,
    output logic        pc_inc,
    output logic        pc_load,
    output logic        alu_en,
    output logic        flags_we,
    output logic        rf_we,
    output logic        instr_done,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        BRANCH = 3'd5
    } state_t;

    state_t      r_state;
    logic [15:0] r_ir;

    logic [2:0]  w_class;
    logic        w_mem_op;
    logic        w_cmp;
    logic        w_flag_op;
    logic        w_cond_undef;

    assign w_class      = r_ir[15:13];
    assign w_mem_op     = (w_class == 3'b011) || (w_class == 3'b100) ||
                          ((w_class == 3'b010) && (r_ir[12] | r_ir[11]));
    assign w_cmp        = (w_class == 3'b001) && (r_ir[12:11] == 2'b01);
    // Memory ops are excluded from flag updates by the EXEC priority below.
    assign w_flag_op    = (w_class == 3'b000) || (w_class == 3'b001) || (w_class == 3'b010);
    assign w_cond_undef = (r_ir[11:8] == 4'hF);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= FETCH;
            r_ir    <= '0;
        end else begin
            case (r_state)
                FETCH: begin
                    if (!halt && imem_ack) begin
                        r_ir    <= imem_rdata;
                        r_state <= DECODE;
                    end
                end
                DECODE: begin
                    case (w_class)
                        3'b110:  r_state <= (!w_cond_undef && cond_pass) ? BRANCH : FETCH;
                        3'b111:  r_state <= BRANCH;
                        default: r_state <= EXEC;
                    endcase
                end
                EXEC: begin
                    if (w_mem_op)
                        r_state <= MEM;
                    else if (w_cmp)
                        r_state <= FETCH;
                    else
                        r_state <= WB;
                end
                MEM: begin
                    if (dmem_ack)
                        r_state <= r_ir[11] ? WB : FETCH;
                end
                WB:      r_state <= FETCH;
                BRANCH:  r_state <= FETCH;
                default: r_state <= FETCH;
            endcase
        end
    end

    // Outputs are decoded from state and handshake inputs, and forced low during reset.
    always_comb begin
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        pc_inc     = 1'b0;
        pc_load    = 1'b0;
        alu_en     = 1'b0;
        flags_we   = 1'b0;
        rf_we      = 1'b0;
        instr_done = 1'b0;
        ir         = '0;
        op_class   = '0;
        state      = '0;
        if (!rst) begin
            ir       = r_ir;
            op_class = w_class;
            state    = r_state;
            case (r_state)
                FETCH: begin
                    imem_req = !halt;
                    pc_inc   = !halt && imem_ack;
                end
                DECODE: begin
                    if (w_class == 3'b110)
                        instr_done = w_cond_undef || !cond_pass;
                end
                EXEC: begin
                    alu_en = 1'b1;
                    if (!w_mem_op) begin
                        flags_we   = w_flag_op;
                        instr_done = w_cmp;
                    end
                end
                MEM: begin
                    dmem_req   = 1'b1;
                    dmem_we    = ~r_ir[11];
                    instr_done = dmem_ack && !r_ir[11];
                end
                WB: begin
                    rf_we      = 1'b1;
                    instr_done = 1'b1;
                end
                BRANCH: begin
                    pc_load    = 1'b1;
                    instr_done = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
